pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch-side program-counter sequencer: holds the PC, advances it, and redirects it on jumps and on taken branches.
- Sits directly downstream of the ALU. It consumes the ALU's branch compare result (compres) in the same cycle the branch instruction is at pc, and its pc output drives instruction memory.
- Provides a start/halt run-control handshake and saturating performance counters for the bench and the top level.

Parameters:
- PC_W, 16, width of the PC and of both target inputs.
- RESET_PC, 0, PC value loaded on reset and on every (re)start.
- CNT_W, 32, width of cycle_count; branch_count is fixed at 16 bits.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- start  in  1  run request; level, sampled in IDLE or HALTED.
- stall  in  1  freeze: the instruction at pc is not committed this cycle.
- branch_en  in  1  the instruction at pc is a branch (ALU op = branch).
- compres  in  1  ALU compare result; meaningful only when branch_en=1.
- branch_target  in  PC_W  destination of a taken branch.
- jump_en  in  1  the instruction at pc is an unconditional jump.
- jump_target  in  PC_W  destination of a jump.
- halt_req  in  1  the instruction at pc is a halt.
- pc  out  PC_W  current fetch address.
- pc_valid  out  1  high only in RUN; the instruction at pc is live.
- halted  out  1  high only in HALTED.
- cycle_count  out  CNT_W  RUN cycles elapsed, stalls included; saturating.
- branch_count  out  16  taken branches plus jumps; saturating.

Behaviour:
- States: IDLE, RUN, HALTED. All outputs are registered.
- Reset, also when asserted mid-run: state=IDLE, pc=RESET_PC, pc_valid=0, halted=0, both counters=0. Reset overrides every other input.
- IDLE:
  - pc is held at RESET_PC.
  - start=1: next cycle state=RUN, pc_valid=1, counters cleared.
- RUN, stall=1:
  - pc is held; all control inputs are ignored, halt_req included.
  - cycle_count still increments.
- RUN, stall=0: exactly one commit per cycle. The next pc is chosen by this priority:
  1. halt_req=1: pc held; next state=HALTED, pc_valid=0, halted=1.
  2. jump_en=1: pc <= jump_target; branch_count+1.
  3. branch_en=1 and compres=1: pc <= branch_target; branch_count+1.
  4. Otherwise, including branch_en=1 with compres=0: pc <= pc+1 modulo 2^PC_W, so all-ones wraps to 0.
- RUN, every cycle: cycle_count+1.
- Redirect latency: a jump or taken branch is visible on pc one cycle after commit. There are no delay slots and no bubbles.
- compres is combinational from the ALU and is sampled at the same edge as branch_en. The sequencer does not register it first.
- HALTED:
  - pc, cycle_count and branch_count are frozen.
  - start=1: pc <= RESET_PC, counters cleared, next state=RUN. start must not be deasserted and reasserted within a single cycle.
  - start is ignored in RUN.
- Counters: both saturate at all-ones and never wrap. The saturated value holds until reset or a restart.
- Illegal combinations (jump_en and branch_en both high) are resolved by the priority order above. They are not flagged.

Decomposition:
- Shared package cpu_pkg holds:
  - the state encoding: IDLE=2'b00, RUN=2'b01, HALTED=2'b10;
  - the ALU opcode constants: add=4'b0000, sub=4'b0001, branch=4'b0100, epar=4'b0101;
  - the ltgt compare selector constants: 0=eq, 1=le, 2=ge.
- One sub-module, sat_counter, parameterised on width with inputs clr and inc. It is instantiated for cycle_count and for branch_count.

Test Plan:
- Reset, then start pulse, no stalls, 5 cycles: pc sequence 0,1,2,3,4; pc_valid=1; cycle_count=5.
- At pc=3, branch_en=1, compres=1, branch_target=16'h0040: next pc=0x40 and branch_count=1. Repeat with compres=0: next pc=4 and branch_count unchanged.
- At pc=7, jump_en=1, jump_target=0x10, plus branch_en=1 and compres=1 with branch_target=0x20: next pc=0x10, because the jump wins.
- halt_req with stall=1 for 2 cycles, then stall=0: state stays RUN through the stall and pc is held at the same value. On the cycle after stall drops, halted=1 and pc_valid=0. Then pulse start: pc=0, counters=0, RUN.
- Preload pc to 16'hFFFF via jump_target=16'hFFFF, then run with no control inputs: next pc=0x0000.
- Reset asserted mid-run with pc=0x25 and cycle_count=9: next cycle state=IDLE, pc=0, counters=0. Separately, force branch_count to 0xFFFE and apply 3 taken branches: it ends at 0xFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, ALU opcodes and compare selectors.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } seq_state_t;

    localparam logic [3:0] ALU_OP_ADD    = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB    = 4'b0001;
    localparam logic [3:0] ALU_OP_BRANCH = 4'b0100;
    localparam logic [3:0] ALU_OP_EPAR   = 4'b0101;

    localparam logic [1:0] LTGT_EQ = 2'd0;
    localparam logic [1:0] LTGT_LE = 2'd1;
    localparam logic [1:0] LTGT_GE = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr and reset both return it to zero.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = (r_count == {W{1'b1}});

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer with start/halt run control and saturating perf counters.
// state  | meaning
// IDLE   | out of reset, pc parked at RESET_PC, waiting for start
// RUN    | one instruction committed per unstalled cycle
// HALTED | halt committed; pc and counters frozen until start
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             compres,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             jump_en,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             halt_req,
    output logic [PC_W-1:0]  pc,
    output logic             pc_valid,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [15:0]      branch_count
);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic            r_pc_valid;
    logic            r_halted;
    logic            w_cnt_clr;
    logic            w_cyc_inc;
    logic            w_br_inc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pc_valid <= (w_state_nxt == ST_RUN);
            r_halted   <= (w_state_nxt == ST_HALTED);
        end
    end

    // compres is taken straight from the ALU in the same cycle as branch_en.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_clr   = 1'b0;
        w_cyc_inc   = 1'b0;
        w_br_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pc_nxt = RESET_PC;
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                w_cyc_inc = 1'b1;
                if (!stall) begin
                    if (halt_req) begin
                        w_state_nxt = ST_HALTED;
                    end else if (jump_en) begin
                        w_pc_nxt = jump_target;
                        w_br_inc = 1'b1;
                    end else if (branch_en && compres) begin
                        w_pc_nxt = branch_target;
                        w_br_inc = 1'b1;
                    end else begin
                        w_pc_nxt = r_pc + 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = RESET_PC;
                    w_cnt_clr   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = RESET_PC;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (w_cnt_clr),
        .inc   (w_cyc_inc),
        .count (cycle_count)
    );

    sat_counter #(.W(16)) u_branch_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (w_cnt_clr),
        .inc   (w_br_inc),
        .count (branch_count)
    );

    assign pc       = r_pc;
    assign pc_valid = r_pc_valid;
    assign halted   = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand sequences, random vs. model.
module tb_pc_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stall;
    logic        branch_en;
    logic        compres;
    logic [15:0] branch_target;
    logic        jump_en;
    logic [15:0] jump_target;
    logic        halt_req;
    logic [15:0] pc;
    logic        pc_valid;
    logic        halted;
    logic [31:0] cycle_count;
    logic [15:0] branch_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: 0 idle, 1 run, 2 halted
    int      m_st;
    longint  m_pc;
    longint  m_cyc;
    longint  m_br;

    pc_sequencer #(.PC_W(16), .RESET_PC(16'h0000), .CNT_W(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .branch_en     (branch_en),
        .compres       (compres),
        .branch_target (branch_target),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .halt_req      (halt_req),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .halted        (halted),
        .cycle_count   (cycle_count),
        .branch_count  (branch_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        st, sl, be, cr;
        logic [15:0] bt;
        logic        je;
        logic [15:0] jt;
        logic        hr;
        logic [15:0] e_pc;
        logic        e_v, e_h;
        logic [31:0] e_cyc;
        logic [15:0] e_br;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic st, logic sl, logic be, logic cr, logic [15:0] bt,
                                logic je, logic [15:0] jt, logic hr, logic [15:0] e_pc,
                                logic e_v, logic e_h, logic [31:0] e_cyc, logic [15:0] e_br);
        vec_t v;
        v.st = st; v.sl = sl; v.be = be; v.cr = cr; v.bt = bt;
        v.je = je; v.jt = jt; v.hr = hr;
        v.e_pc = e_pc; v.e_v = e_v; v.e_h = e_h; v.e_cyc = e_cyc; v.e_br = e_br;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic st, input logic sl, input logic be, input logic cr,
                          input logic [15:0] bt, input logic je, input logic [15:0] jt,
                          input logic hr);
        start = st; stall = sl; branch_en = be; compres = cr;
        branch_target = bt; jump_en = je; jump_target = jt; halt_req = hr;
    endtask

    task automatic clear_in();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    endtask

    function automatic longint sat_add(longint v, longint maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_st = 0; m_pc = 0; m_cyc = 0; m_br = 0;
        end else if (m_st == 0) begin
            m_pc = 0;
            if (start) begin m_st = 1; m_cyc = 0; m_br = 0; end
        end else if (m_st == 1) begin
            m_cyc = sat_add(m_cyc, 64'hFFFF_FFFF);
            if (!stall) begin
                if (halt_req) m_st = 2;
                else if (jump_en) begin m_pc = jump_target; m_br = sat_add(m_br, 65535); end
                else if (branch_en && compres) begin m_pc = branch_target; m_br = sat_add(m_br, 65535); end
                else m_pc = (m_pc + 1) % 65536;
            end
        end else begin
            if (start) begin m_st = 1; m_pc = 0; m_cyc = 0; m_br = 0; end
        end
    endtask

    // advance one edge, update the model with the inputs sampled at that edge, compare
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check("model.pc", pc, m_pc);
        check("model.pc_valid", pc_valid, (m_st == 1) ? 1 : 0);
        check("model.halted", halted, (m_st == 2) ? 1 : 0);
        check("model.cycle_count", cycle_count, m_cyc);
        check("model.branch_count", branch_count, m_br);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_in();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        m_st = 0; m_pc = 0; m_cyc = 0; m_br = 0;
        reset = 1'b1;
        clear_in();

        //            st sl be cr bt       je jt        hr  pc       v  h  cyc br
        vecs[0]  = mk(1, 0, 0, 0, 16'h0,  0, 16'h0,    0, 16'h0000, 1, 0, 0,  0);
        vecs[1]  = mk(0, 0, 0, 0, 16'h0,  0, 16'h0,    0, 16'h0001, 1, 0, 1,  0);
        vecs[2]  = mk(0, 0, 0, 0, 16'h0,  0, 16'h0,    0, 16'h0002, 1, 0, 2,  0);
        vecs[3]  = mk(0, 0, 0, 0, 16'h0,  0, 16'h0,    0, 16'h0003, 1, 0, 3,  0);
        vecs[4]  = mk(0, 0, 0, 0, 16'h0,  0, 16'h0,    0, 16'h0004, 1, 0, 4,  0);
        vecs[5]  = mk(0, 0, 0, 0, 16'h0,  0, 16'h0,    0, 16'h0005, 1, 0, 5,  0);
        vecs[6]  = mk(0, 0, 0, 0, 16'h0,  1, 16'h3,    0, 16'h0003, 1, 0, 6,  1);
        vecs[7]  = mk(0, 0, 1, 1, 16'h40, 0, 16'h0,    0, 16'h0040, 1, 0, 7,  2);
        vecs[8]  = mk(0, 0, 0, 0, 16'h0,  1, 16'h3,    0, 16'h0003, 1, 0, 8,  3);
        vecs[9]  = mk(0, 0, 1, 0, 16'h40, 0, 16'h0,    0, 16'h0004, 1, 0, 9,  3);
        vecs[10] = mk(0, 0, 0, 0, 16'h0,  1, 16'h7,    0, 16'h0007, 1, 0, 10, 4);
        vecs[11] = mk(0, 0, 1, 1, 16'h20, 1, 16'h10,   0, 16'h0010, 1, 0, 11, 5);
        vecs[12] = mk(0, 1, 0, 0, 16'h0,  0, 16'h0,    1, 16'h0010, 1, 0, 12, 5);
        vecs[13] = mk(0, 1, 0, 0, 16'h0,  0, 16'h0,    1, 16'h0010, 1, 0, 13, 5);
        vecs[14] = mk(0, 0, 0, 0, 16'h0,  0, 16'h0,    1, 16'h0010, 0, 1, 14, 5);
        vecs[15] = mk(0, 0, 0, 0, 16'h0,  0, 16'h0,    0, 16'h0010, 0, 1, 14, 5);
        vecs[16] = mk(0, 0, 0, 0, 16'h0,  1, 16'h55,   0, 16'h0010, 0, 1, 14, 5);
        vecs[17] = mk(1, 0, 0, 0, 16'h0,  0, 16'h0,    0, 16'h0000, 1, 0, 0,  0);
        vecs[18] = mk(0, 0, 0, 0, 16'h0,  1, 16'hFFFF, 0, 16'hFFFF, 1, 0, 1,  1);
        vecs[19] = mk(0, 0, 0, 0, 16'h0,  0, 16'h0,    0, 16'h0000, 1, 0, 2,  1);
        vecs[20] = mk(1, 0, 0, 0, 16'h0,  0, 16'h0,    0, 16'h0001, 1, 0, 3,  1);
        vecs[21] = mk(0, 1, 0, 0, 16'h0,  1, 16'h99,   0, 16'h0001, 1, 0, 4,  1);

        do_reset();
        check("reset.pc", pc, 0);
        check("reset.pc_valid", pc_valid, 0);
        check("reset.halted", halted, 0);
        check("reset.cycle_count", cycle_count, 0);
        check("reset.branch_count", branch_count, 0);

        // idle holds with start low
        tick();
        check("idle.pc_valid", pc_valid, 0);

        for (int i = 0; i < 22; i++) begin
            set_in(vecs[i].st, vecs[i].sl, vecs[i].be, vecs[i].cr,
                   vecs[i].bt, vecs[i].je, vecs[i].jt, vecs[i].hr);
            tick();
            check($sformatf("vec%0d.pc", i), pc, vecs[i].e_pc);
            check($sformatf("vec%0d.pc_valid", i), pc_valid, vecs[i].e_v);
            check($sformatf("vec%0d.halted", i), halted, vecs[i].e_h);
            check($sformatf("vec%0d.cycle_count", i), cycle_count, vecs[i].e_cyc);
            check($sformatf("vec%0d.branch_count", i), branch_count, vecs[i].e_br);
        end

        // mid-run reset at pc=0x25, cycle_count=9
        do_reset();
        set_in(1, 0, 0, 0, 16'h0, 0, 16'h0, 0);
        tick();
        clear_in();
        for (int i = 0; i < 8; i++) tick();
        set_in(0, 0, 0, 0, 16'h0, 1, 16'h25, 0);
        tick();
        check("midrst.pre_pc", pc, 16'h25);
        check("midrst.pre_cyc", cycle_count, 9);
        clear_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst.pc", pc, 0);
        check("midrst.pc_valid", pc_valid, 0);
        check("midrst.halted", halted, 0);
        check("midrst.cycle_count", cycle_count, 0);
        check("midrst.branch_count", branch_count, 0);

        // branch_count saturation: 65534 jumps, then 3 taken branches
        set_in(1, 0, 0, 0, 16'h0, 0, 16'h0, 0);
        tick();
        set_in(0, 0, 0, 0, 16'h0, 1, 16'h0100, 0);
        for (int i = 0; i < 65534; i++) tick();
        check("sat.pre", branch_count, 16'hFFFE);
        set_in(0, 0, 1, 1, 16'h0200, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) tick();
        check("sat.final", branch_count, 16'hFFFF);
        check("sat.pc", pc, 16'h0200);

        // randomized run against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            reset         = ($urandom_range(0, 63) == 0);
            start         = ($urandom_range(0, 5) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_en     = ($urandom_range(0, 2) == 0);
            compres       = $urandom_range(0, 1) != 0;
            branch_target = 16'($urandom);
            jump_en       = ($urandom_range(0, 7) == 0);
            jump_target   = 16'($urandom);
            halt_req      = ($urandom_range(0, 19) == 0);
            tick();
        end
        reset = 1'b0;
        clear_in();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
